// File: rtl/seq_mag_cmp_if.sv
// Handshake bundle for the sequential magnitude comparator: operand channel in, result channel out.
interface seq_mag_cmp_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             out_valid;
  logic             out_ready;
  logic             gt;
  logic             lt;
  logic             eq;
  logic             busy;

  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, gt, lt, eq, busy
  );

  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, gt, lt, eq, busy
  );
endinterface

// File: rtl/seq_mag_cmp.sv
// Multi-cycle WIDTH-bit magnitude comparator: CHUNK bits per clock, MSB chunk first,
// early exit on the first differing chunk, signed compares via offset-binary mapping.
module seq_mag_cmp #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic          clk,
  input logic          rst_n,
  seq_mag_cmp_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  generate
    if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("seq_mag_cmp: CHUNK must divide WIDTH exactly and WIDTH must be >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_e;

  state_e           state_q;
  logic [IDXW-1:0]  idx_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             gt_q;
  logic             lt_q;
  logic             eq_q;

  logic [WIDTH-1:0] signFlip;
  logic [CHUNK-1:0] aChunk;
  logic [CHUNK-1:0] bChunk;

  // Operands shift left after each equal chunk, so the chunk under test always sits at the top.
  assign signFlip = {bus.signed_mode, {(WIDTH-1){1'b0}}};
  assign aChunk   = a_q[WIDTH-1 -: CHUNK];
  assign bChunk   = b_q[WIDTH-1 -: CHUNK];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a ^ signFlip;
            b_q     <= bus.b ^ signFlip;
            idx_q   <= '0;
            state_q <= CMP;
          end
        end
        CMP: begin
          if (aChunk != bChunk) begin
            gt_q    <= (aChunk > bChunk);
            lt_q    <= (aChunk < bChunk);
            eq_q    <= 1'b0;
            state_q <= DONE;
          end else if (idx_q == LAST_IDX) begin
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + IDXW'(1);
            a_q   <= a_q << CHUNK;
            b_q   <= b_q << CHUNK;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.gt        = gt_q;
  assign bus.lt        = lt_q;
  assign bus.eq        = eq_q;
endmodule

// File: tb/tb_seq_mag_cmp.sv
// Self-checking bench for seq_mag_cmp: directed scenarios on CHUNK=4 plus randomized
// sweeps on CHUNK=4, 16 and 1 against an arithmetic reference model.
module tb_seq_mag_cmp;
  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] LT = 3'b010;
  localparam logic [2:0] EQ = 3'b001;
  localparam int TIMEOUT = 40;

  logic clk;
  logic rst_n;
  int   checks;
  int   passes;

  seq_mag_cmp_if #(.WIDTH(16)) if4  ();
  seq_mag_cmp_if #(.WIDTH(16)) if16 ();
  seq_mag_cmp_if #(.WIDTH(16)) if1  ();

  seq_mag_cmp #(.WIDTH(16), .CHUNK(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  seq_mag_cmp #(.WIDTH(16), .CHUNK(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));
  seq_mag_cmp #(.WIDTH(16), .CHUNK(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one DUT's input side; sel 0 -> CHUNK=4, 1 -> CHUNK=16, 2 -> CHUNK=1.
  task automatic setIn(input int sel, input logic v, input logic [15:0] av, input logic [15:0] bv,
                       input logic sm, input logic rdy);
    case (sel)
      0: begin if4.in_valid = v;  if4.a = av;  if4.b = bv;  if4.signed_mode = sm;  if4.out_ready = rdy;  end
      1: begin if16.in_valid = v; if16.a = av; if16.b = bv; if16.signed_mode = sm; if16.out_ready = rdy; end
      default: begin if1.in_valid = v; if1.a = av; if1.b = bv; if1.signed_mode = sm; if1.out_ready = rdy; end
    endcase
  endtask

  // Returns {in_ready, out_valid, busy, gt, lt, eq}.
  function automatic logic [5:0] getOut(input int sel);
    case (sel)
      0:       return {if4.in_ready, if4.out_valid, if4.busy, if4.gt, if4.lt, if4.eq};
      1:       return {if16.in_ready, if16.out_valid, if16.busy, if16.gt, if16.lt, if16.eq};
      default: return {if1.in_ready, if1.out_valid, if1.busy, if1.gt, if1.lt, if1.eq};
    endcase
  endfunction

  // Reference: ordering from plain (signed or unsigned) arithmetic; latency from the
  // position of the most significant differing bit.
  function automatic void refModel(input logic [15:0] a, input logic [15:0] b, input logic sm,
                                   input int chunk, output logic [2:0] res, output int lat);
    if (a == b) res = EQ;
    else if (sm ? ($signed(a) > $signed(b)) : (a > b)) res = GT;
    else res = LT;
    lat = 16 / chunk;
    for (int i = 15; i >= 0; i--) begin
      if (a[i] != b[i]) begin
        lat = (15 - i) / chunk + 1;
        break;
      end
    end
  endfunction

  // Issue one transaction with out_ready high; called and returns at a falling edge with the DUT idle.
  task automatic runCompare(input int sel, input logic [15:0] av, input logic [15:0] bv, input logic sm,
                            output int lat, output logic [2:0] res, output bit ok);
    logic [5:0] o;
    setIn(sel, 1'b1, av, bv, sm, 1'b1);
    @(posedge clk);
    #1;
    setIn(sel, 1'b0, av, bv, sm, 1'b1);
    ok  = 1'b0;
    lat = 0;
    res = '0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(posedge clk);
      @(negedge clk);
      o = getOut(sel);
      if (o[4]) begin
        lat = k;
        res = o[2:0];
        ok  = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [5:0] o;
    int lat;
    logic [2:0] res;
    bit ok;
    bit seen;
    rst_n = 1'b0;
    setIn(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    setIn(1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    setIn(2, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    #3;
    for (int s = 0; s < 3; s++) begin
      o = getOut(s);
      checks++;
      if (o !== 6'b100000) $display("[TB] FAIL reset_state dut%0d: got %b expected %b", s, o, 6'b100000);
      else passes++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    runCompare(0, 16'h8000, 16'h7FFF, 1'b0, lat, res, ok);
    checks++;
    if (!ok || res !== GT) $display("[TB] FAIL pre_reset_gt: got %b (ok=%0d) expected %b", res, ok, GT);
    else passes++;
    setIn(0, 1'b1, 16'h1234, 16'h1235, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    setIn(0, 1'b0, 16'h1234, 16'h1235, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    o = getOut(0);
    checks++;
    if (o !== 6'b100000) $display("[TB] FAIL reset_mid_cmp: got %b expected %b", o, 6'b100000);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      o = getOut(0);
      if (o[4] || !o[5]) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) $display("[TB] FAIL reset_no_result: got result/busy=%0d expected 0", seen);
    else passes++;
  endtask

  task automatic test_early_exit();
    int lat;
    logic [2:0] res;
    bit ok;
    runCompare(0, 16'h8000, 16'h7FFF, 1'b0, lat, res, ok);
    checks++;
    if (!ok || res !== GT) $display("[TB] FAIL early_exit_result: got %b expected %b", res, GT);
    else passes++;
    checks++;
    if (lat !== 1) $display("[TB] FAIL early_exit_latency: got %0d expected 1", lat);
    else passes++;
  endtask

  task automatic test_full_depth();
    int lat;
    logic [2:0] res;
    bit ok;
    runCompare(0, 16'h1234, 16'h1235, 1'b0, lat, res, ok);
    checks++;
    if (!ok || res !== LT || lat !== 4)
      $display("[TB] FAIL full_depth_lt: got res=%b lat=%0d expected res=%b lat=4", res, lat, LT);
    else passes++;
    runCompare(0, 16'hBEEF, 16'hBEEF, 1'b0, lat, res, ok);
    checks++;
    if (!ok || res !== EQ || lat !== 4)
      $display("[TB] FAIL full_depth_eq: got res=%b lat=%0d expected res=%b lat=4", res, lat, EQ);
    else passes++;
  endtask

  task automatic test_signed();
    int lat;
    logic [2:0] res;
    bit ok;
    runCompare(0, 16'h8000, 16'h0001, 1'b1, lat, res, ok);
    checks++;
    if (!ok || res !== LT) $display("[TB] FAIL signed_neg_vs_pos: got %b expected %b", res, LT);
    else passes++;
    runCompare(0, 16'h8000, 16'h0001, 1'b0, lat, res, ok);
    checks++;
    if (!ok || res !== GT) $display("[TB] FAIL unsigned_8000_vs_1: got %b expected %b", res, GT);
    else passes++;
    runCompare(0, 16'hFFFF, 16'hFFFE, 1'b1, lat, res, ok);
    checks++;
    if (!ok || res !== GT || lat !== 4)
      $display("[TB] FAIL signed_m1_vs_m2: got res=%b lat=%0d expected res=%b lat=4", res, lat, GT);
    else passes++;
  endtask

  task automatic test_backpressure();
    logic [5:0] o;
    int lat;
    bit ok;
    setIn(0, 1'b1, 16'h00F0, 16'h00E0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    setIn(0, 1'b0, 16'h0000, 16'hFFFF, 1'b1, 1'b0);
    ok  = 1'b0;
    lat = 0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(posedge clk);
      @(negedge clk);
      o = getOut(0);
      if (o[4]) begin
        lat = k;
        ok  = 1'b1;
        break;
      end
      setIn(0, 1'b0, 16'(k * 16'h1111), ~16'(k * 16'h1111), k[0], 1'b0);
    end
    checks++;
    if (!ok || o[2:0] !== GT || lat !== 3)
      $display("[TB] FAIL bp_result: got res=%b lat=%0d expected res=%b lat=3", o[2:0], lat, GT);
    else passes++;
    for (int c = 0; c < 5; c++) begin
      o = getOut(0);
      checks++;
      if (o !== 6'b011100) $display("[TB] FAIL bp_hold_%0d: got %b expected %b", c, o, 6'b011100);
      else passes++;
      setIn(0, 1'b1, 16'h0000, 16'hFFFF, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
    end
    setIn(0, 1'b1, 16'h0001, 16'h0002, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    o = getOut(0);
    checks++;
    if (o !== 6'b100100) $display("[TB] FAIL bp_release_idle: got %b expected %b", o, 6'b100100);
    else passes++;
    @(posedge clk);
    #1;
    setIn(0, 1'b0, 16'h0001, 16'h0002, 1'b0, 1'b1);
    @(negedge clk);
    o = getOut(0);
    checks++;
    if (o[5:3] !== 3'b001) $display("[TB] FAIL bp_next_accept: got %b expected %b", o[5:3], 3'b001);
    else passes++;
    ok = 1'b0;
    for (int k = 0; k < TIMEOUT; k++) begin
      if (o[4]) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      @(negedge clk);
      o = getOut(0);
    end
    checks++;
    if (!ok || o[2:0] !== LT) $display("[TB] FAIL bp_next_result: got %b (ok=%0d) expected %b", o[2:0], ok, LT);
    else passes++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_sweep(input int sel, input int chunk, input int n);
    logic [15:0] a;
    logic [15:0] b;
    logic sm;
    logic [2:0] res;
    logic [2:0] expRes;
    int lat;
    int expLat;
    bit ok;
    int errs;
    errs = 0;
    for (int t = 0; t < n; t++) begin
      a  = 16'($urandom);
      sm = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       b = 16'($urandom);
        1:       b = a;
        2:       b = a ^ (16'h1 << $urandom_range(0, 15));
        default: b = {a[15:6], 6'($urandom)};
      endcase
      refModel(a, b, sm, chunk, expRes, expLat);
      runCompare(sel, a, b, sm, lat, res, ok);
      checks++;
      if (!ok || res !== expRes) begin
        if (errs < 10)
          $display("[TB] FAIL sweep_c%0d_result a=%h b=%h sm=%0d: got %b expected %b", chunk, a, b, sm, res, expRes);
        errs++;
      end else passes++;
      checks++;
      if (lat !== expLat) begin
        if (errs < 10)
          $display("[TB] FAIL sweep_c%0d_latency a=%h b=%h: got %0d expected %0d", chunk, a, b, lat, expLat);
        errs++;
      end else passes++;
    end
  endtask

  initial begin
    checks = 0;
    passes = 0;
    test_reset();
    test_early_exit();
    test_full_depth();
    test_signed();
    test_backpressure();
    test_sweep(0, 4, 1000);
    test_sweep(1, 16, 1000);
    test_sweep(2, 1, 1000);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, passed %0d of %0d", passes, checks);
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
